line_engine_v2: RTL and testbench

- Parametrised successor to the single-pixel line engine; draws into the DDR frame buffer through the address FIFO (af) and write-data FIFO (wdf).
- Two modes:
  - LINE: inclusive-endpoint Bresenham, one pixel per burst.
  - RECT: filled rectangle with span coalescing, up to 8 pixels per burst.
- Sits between the CPU's memory-mapped graphics registers and the MIG FIFOs, alongside the pixel feeder.

---
 rtl/line_engine_v2_if.sv | 21 ++
 rtl/line_engine_v2.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_line_engine_v2.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_engine_v2_if.sv
// MIG-side bus of the line engine: address FIFO and write-data FIFO with their full flags.
// The engine is the master; the FIFO side (or a bench model) is the slave.
interface line_engine_v2_if;
  logic         af_full;
  logic         wdf_full;
  logic [30:0]  af_addr_din;
  logic         af_wr_en;
  logic [127:0] wdf_din;
  logic [15:0]  wdf_mask_din;
  logic         wdf_wr_en;

  modport master (
    input  af_full, wdf_full,
    output af_addr_din, af_wr_en, wdf_din, wdf_mask_din, wdf_wr_en
  );

  modport slave (
    output af_full, wdf_full,
    input  af_addr_din, af_wr_en, wdf_din, wdf_mask_din, wdf_wr_en
  );
endinterface

// File: rtl/line_engine_v2.sv
// Line/rectangle engine: Bresenham lines (one pixel per burst) and filled rectangles
// (up to 8 pixels per burst) written into the frame buffer through the MIG FIFOs.
module line_engine_v2 #(
  parameter int COORD_W = 10,
  parameter int ERR_W   = COORD_W + 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic               LE_ready,
  output logic               LE_done,
  input  logic [31:0]        LE_color,
  input  logic [COORD_W-1:0] LE_point,
  input  logic               LE_color_valid,
  input  logic               LE_x0_valid,
  input  logic               LE_y0_valid,
  input  logic               LE_x1_valid,
  input  logic               LE_y1_valid,
  input  logic               LE_mode,
  input  logic               LE_trigger,
  input  logic [31:0]        LE_frame_base,
  line_engine_v2_if.master   mig
);

  localparam int GW = COORD_W - 3;
  localparam int AW = 2 * COORD_W + 5;

  localparam logic [COORD_W-1:0] ONE_C = COORD_W'(1);
  localparam logic [GW-1:0]      ONE_G = GW'(1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SEND1 = 3'd2;
  localparam logic [2:0] S_SEND2 = 3'd3;
  localparam logic [2:0] S_STEP  = 3'd4;

  function automatic logic [15:0] beat_mask(input logic [3:0] en);
    logic [15:0] m;
    m = 16'hFFFF;
    for (int p = 0; p < 4; p++) begin
      m[15-4*p -: 4] = en[p] ? 4'h0 : 4'hF;
    end
    return m;
  endfunction

  function automatic logic [30:0] burst_addr(input logic [5:0] fb,
                                             input logic [COORD_W-1:0] y,
                                             input logic [GW-1:0] g);
    logic [AW-1:0] a;
    a = {fb, y, g, 2'b00};
    return 31'(a);
  endfunction

  logic [2:0]         state_q, state_d;
  logic [COORD_W-1:0] x0_q, y0_q, x1_q, y1_q;
  logic [31:0]        color_q;

  logic [COORD_W-1:0] sx0_q, sy0_q, sx1_q, sy1_q, sx0_d, sy0_d, sx1_d, sy1_d;
  logic [31:0]        scol_q, scol_d;
  logic               mode_q, mode_d;
  logic [5:0]         fb_q, fb_d;

  logic               steep_q, steep_d, yneg_q, yneg_d;
  logic [COORD_W-1:0] major_q, major_d, minor_q, minor_d, major_end_q, major_end_d;
  logic [COORD_W-1:0] dx_q, dx_d, dy_q, dy_d;
  logic signed [ERR_W-1:0] err_q, err_d, err_sub_s, err_nxt_s;

  logic [COORD_W-1:0] xmin_q, xmin_d, xmax_q, xmax_d, ymax_q, ymax_d, row_q, row_d;
  logic [GW-1:0]      grp_q, grp_d;

  logic [30:0]        addr_q, addr_d;
  logic [15:0]        mask_q, mask_d, mask2_q, mask2_d;
  logic [127:0]       data_q, data_d;

  logic [COORD_W-1:0] adx_s, ady_s, a0_s, b0_s, a1_s, b1_s;
  logic [COORD_W-1:0] ma_s, mb_s, ea_s, eb_s, ldx_s, ldy_s, minor_nxt_s;
  logic               steep_s, swap_s, err_neg_s, last_s, send1_ok_s, send2_ok_s, load_s;
  logic [COORD_W-1:0] px_s, py_s, brow_s, bx;
  logic [GW-1:0]      bgrp_s;
  logic [7:0]         en_s;
  logic               unused_fb_s;

  assign unused_fb_s = ^{LE_frame_base[31:28], LE_frame_base[21:0]};

  // Setup: choose the major axis and order endpoints so the major coordinate ascends.
  assign adx_s   = (sx1_q >= sx0_q) ? (sx1_q - sx0_q) : (sx0_q - sx1_q);
  assign ady_s   = (sy1_q >= sy0_q) ? (sy1_q - sy0_q) : (sy0_q - sy1_q);
  assign steep_s = ady_s > adx_s;
  assign a0_s    = steep_s ? sy0_q : sx0_q;
  assign b0_s    = steep_s ? sx0_q : sy0_q;
  assign a1_s    = steep_s ? sy1_q : sx1_q;
  assign b1_s    = steep_s ? sx1_q : sy1_q;
  assign swap_s  = a0_s > a1_s;
  assign ma_s    = swap_s ? a1_s : a0_s;
  assign mb_s    = swap_s ? b1_s : b0_s;
  assign ea_s    = swap_s ? a0_s : a1_s;
  assign eb_s    = swap_s ? b0_s : b1_s;
  assign ldx_s   = ea_s - ma_s;
  assign ldy_s   = (eb_s >= mb_s) ? (eb_s - mb_s) : (mb_s - eb_s);

  assign err_sub_s   = err_q - $signed(ERR_W'(dy_q));
  assign err_neg_s   = err_sub_s[ERR_W-1];
  assign err_nxt_s   = err_neg_s ? (err_sub_s + $signed(ERR_W'(dx_q))) : err_sub_s;
  assign minor_nxt_s = err_neg_s ? (yneg_q ? (minor_q - ONE_C) : (minor_q + ONE_C)) : minor_q;

  assign last_s = mode_q ? ((grp_q == xmax_q[COORD_W-1:3]) && (row_q == ymax_q))
                         : (major_q == major_end_q);

  assign send1_ok_s = (state_q == S_SEND1) & ~mig.af_full & ~mig.wdf_full;
  assign send2_ok_s = (state_q == S_SEND2) & ~mig.wdf_full;

  // Sequencer and cursor next-state.
  always_comb begin
    state_d     = state_q;
    sx0_d       = sx0_q;
    sy0_d       = sy0_q;
    sx1_d       = sx1_q;
    sy1_d       = sy1_q;
    scol_d      = scol_q;
    mode_d      = mode_q;
    fb_d        = fb_q;
    steep_d     = steep_q;
    yneg_d      = yneg_q;
    major_d     = major_q;
    minor_d     = minor_q;
    major_end_d = major_end_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    err_d       = err_q;
    xmin_d      = xmin_q;
    xmax_d      = xmax_q;
    ymax_d      = ymax_q;
    grp_d       = grp_q;
    row_d       = row_q;
    case (state_q)
      S_IDLE: begin
        if (LE_trigger) begin
          state_d = S_SETUP;
          sx0_d   = x0_q;
          sy0_d   = y0_q;
          sx1_d   = x1_q;
          sy1_d   = y1_q;
          scol_d  = color_q;
          mode_d  = LE_mode;
          fb_d    = LE_frame_base[27:22];
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        state_d     = S_SEND1;
        steep_d     = steep_s;
        yneg_d      = mb_s > eb_s;
        major_d     = ma_s;
        minor_d     = mb_s;
        major_end_d = ea_s;
        dx_d        = ldx_s;
        dy_d        = ldy_s;
        err_d       = ERR_W'({1'b0, ldx_s[COORD_W-1:1]});
        xmin_d      = (sx0_q <= sx1_q) ? sx0_q : sx1_q;
        xmax_d      = (sx0_q <= sx1_q) ? sx1_q : sx0_q;
        ymax_d      = (sy0_q <= sy1_q) ? sy1_q : sy0_q;
        row_d       = (sy0_q <= sy1_q) ? sy0_q : sy1_q;
        grp_d       = xmin_d[COORD_W-1:3];
      end
      S_SEND1: begin
        state_d = send1_ok_s ? S_SEND2 : S_SEND1;
      end
      S_SEND2: begin
        state_d = send2_ok_s ? S_STEP : S_SEND2;
      end
      S_STEP: begin
        if (last_s) begin
          state_d = S_IDLE;
        end else if (mode_q) begin
          state_d = S_SEND1;
          if (grp_q != xmax_q[COORD_W-1:3]) begin
            grp_d = grp_q + ONE_G;
          end else begin
            grp_d = xmin_q[COORD_W-1:3];
            row_d = row_q + ONE_C;
          end
        end else begin
          state_d = S_SEND1;
          major_d = major_q + ONE_C;
          minor_d = minor_nxt_s;
          err_d   = err_nxt_s;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign px_s   = steep_d ? minor_d : major_d;
  assign py_s   = steep_d ? major_d : minor_d;
  assign bgrp_s = mode_d ? grp_d : px_s[COORD_W-1:3];
  assign brow_s = mode_d ? row_d : py_s;
  assign load_s = (state_d == S_SEND1) && (state_q != S_SEND1);

  // Pixel enables of the burst about to be issued (RECT clips the group to [xmin,xmax]).
  always_comb begin
    bx   = '0;
    en_s = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bx = {grp_d, i[2:0]};
      if (mode_d) begin
        en_s[i] = (bx >= xmin_d) && (bx <= xmax_d);
      end else begin
        en_s[i] = (px_s[2:0] == i[2:0]);
      end
    end
  end

  // Burst output registers: loaded on entry to SEND1, beat-2 mask swapped in on SEND1 -> SEND2.
  always_comb begin
    if (load_s) begin
      addr_d  = burst_addr(fb_d, brow_s, bgrp_s);
      mask_d  = beat_mask(en_s[3:0]);
      mask2_d = beat_mask(en_s[7:4]);
      data_d  = {4{scol_d}};
    end else if (send1_ok_s) begin
      addr_d  = addr_q;
      mask_d  = mask2_q;
      mask2_d = mask2_q;
      data_d  = data_q;
    end else begin
      addr_d  = addr_q;
      mask_d  = mask_q;
      mask2_d = mask2_q;
      data_d  = data_q;
    end
  end

  // Load registers follow their strobes in any state.
  always_ff @(posedge clk) begin
    if (rst) begin
      x0_q    <= '0;
      y0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      color_q <= 32'h0;
    end else begin
      if (LE_x0_valid)    x0_q    <= LE_point;
      if (LE_y0_valid)    y0_q    <= LE_point;
      if (LE_x1_valid)    x1_q    <= LE_point;
      if (LE_y1_valid)    y1_q    <= LE_point;
      if (LE_color_valid) color_q <= LE_color;
    end
  end

  // Engine state; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sx0_q       <= '0;
      sy0_q       <= '0;
      sx1_q       <= '0;
      sy1_q       <= '0;
      scol_q      <= 32'h0;
      mode_q      <= 1'b0;
      fb_q        <= 6'h0;
      steep_q     <= 1'b0;
      yneg_q      <= 1'b0;
      major_q     <= '0;
      minor_q     <= '0;
      major_end_q <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      err_q       <= '0;
      xmin_q      <= '0;
      xmax_q      <= '0;
      ymax_q      <= '0;
      grp_q       <= '0;
      row_q       <= '0;
      addr_q      <= 31'h0;
      mask_q      <= 16'h0;
      mask2_q     <= 16'h0;
      data_q      <= 128'h0;
    end else begin
      state_q     <= state_d;
      sx0_q       <= sx0_d;
      sy0_q       <= sy0_d;
      sx1_q       <= sx1_d;
      sy1_q       <= sy1_d;
      scol_q      <= scol_d;
      mode_q      <= mode_d;
      fb_q        <= fb_d;
      steep_q     <= steep_d;
      yneg_q      <= yneg_d;
      major_q     <= major_d;
      minor_q     <= minor_d;
      major_end_q <= major_end_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      err_q       <= err_d;
      xmin_q      <= xmin_d;
      xmax_q      <= xmax_d;
      ymax_q      <= ymax_d;
      grp_q       <= grp_d;
      row_q       <= row_d;
      addr_q      <= addr_d;
      mask_q      <= mask_d;
      mask2_q     <= mask2_d;
      data_q      <= data_d;
    end
  end

  assign LE_ready         = (state_q == S_IDLE);
  assign LE_done          = send2_ok_s & last_s;
  assign mig.af_wr_en     = send1_ok_s;
  assign mig.wdf_wr_en    = send1_ok_s | send2_ok_s;
  assign mig.af_addr_din  = addr_q;
  assign mig.wdf_din      = data_q;
  assign mig.wdf_mask_din = mask_q;

endmodule

// File: tb/tb_line_engine_v2.sv
// Directed bench for line_engine_v2: stimulus pushes expected beats into a queue,
// a negedge monitor pops and compares every data-FIFO write.
module tb_line_engine_v2;

  logic        clk = 1'b0;
  logic        rst;
  logic        LE_ready, LE_done;
  logic [31:0] LE_color;
  logic [9:0]  LE_point;
  logic        LE_color_valid, LE_x0_valid, LE_y0_valid, LE_x1_valid, LE_y1_valid;
  logic        LE_mode, LE_trigger;
  logic [31:0] LE_frame_base;

  line_engine_v2_if bus ();

  line_engine_v2 #(.COORD_W(10)) dut (
    .clk            (clk),
    .rst            (rst),
    .LE_ready       (LE_ready),
    .LE_done        (LE_done),
    .LE_color       (LE_color),
    .LE_point       (LE_point),
    .LE_color_valid (LE_color_valid),
    .LE_x0_valid    (LE_x0_valid),
    .LE_y0_valid    (LE_y0_valid),
    .LE_x1_valid    (LE_x1_valid),
    .LE_y1_valid    (LE_y1_valid),
    .LE_mode        (LE_mode),
    .LE_trigger     (LE_trigger),
    .LE_frame_base  (LE_frame_base),
    .mig            (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [30:0]  addr;
    logic [15:0]  mask;
    logic [127:0] data;
    logic         done;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_e;
  int    checks = 0;
  int    errors = 0;
  int    af_cnt = 0;
  int    wdf_cnt = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_burst(input logic [30:0] a, input logic [15:0] m1, input logic [15:0] m2,
                            input logic [31:0] col, input logic last);
    beat_t b;
    b.addr = a; b.mask = m1; b.data = {4{col}}; b.done = 1'b0;
    exp_q.push_back(b);
    b.mask = m2; b.done = last;
    exp_q.push_back(b);
  endtask

  // Single-pixel burst at (x,y) with frame-base field 1.
  task automatic push_pix(input int x, input int y, input logic [31:0] col, input logic last);
    logic [30:0] a;
    logic [15:0] m1, m2;
    int p;
    a  = 31'(32'h0008_0000 + y * 512 + (x / 8) * 4);
    p  = x % 8;
    m1 = 16'hFFFF;
    m2 = 16'hFFFF;
    if (p < 4) m1[15-4*p -: 4] = 4'h0;
    else       m2[15-4*(p-4) -: 4] = 4'h0;
    push_burst(a, m1, m2, col, last);
  endtask

  task automatic load(input int x0, input int y0, input int x1, input int y1, input logic [31:0] col);
    LE_point = 10'(x0); LE_x0_valid = 1'b1; tick(); LE_x0_valid = 1'b0;
    LE_point = 10'(y0); LE_y0_valid = 1'b1; tick(); LE_y0_valid = 1'b0;
    LE_point = 10'(x1); LE_x1_valid = 1'b1; tick(); LE_x1_valid = 1'b0;
    LE_point = 10'(y1); LE_y1_valid = 1'b1; tick(); LE_y1_valid = 1'b0;
    LE_color = col; LE_color_valid = 1'b1; tick(); LE_color_valid = 1'b0;
  endtask

  task automatic trigger(input logic m);
    af_cnt = 0;
    wdf_cnt = 0;
    LE_mode = m; LE_trigger = 1'b1; tick(); LE_trigger = 1'b0;
  endtask

  task automatic finish_op(input string name, input int n_bursts);
    int n;
    n = 0;
    while (!LE_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_ready"}, LE_ready, 1'b1);
    chk({name, "_queue_left"}, exp_q.size(), 0);
    chk({name, "_af_count"}, af_cnt, n_bursts);
    chk({name, "_wdf_count"}, wdf_cnt, 2 * n_bursts);
    exp_q.delete();
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (LE_done === 1'b1) chk("done_with_beat", bus.wdf_wr_en, 1'b1);
    if (bus.af_wr_en === 1'b1) begin
      af_cnt++;
      chk("af_pairs_wdf", bus.wdf_wr_en, 1'b1);
    end
    if (bus.wdf_wr_en === 1'b1) begin
      wdf_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got addr %h mask %h expected no write", bus.af_addr_din, bus.wdf_mask_din);
      end else begin
        mon_e = exp_q.pop_front();
        chk("beat_addr", bus.af_addr_din, mon_e.addr);
        chk("beat_mask", bus.wdf_mask_din, mon_e.mask);
        chk("beat_data", bus.wdf_din, mon_e.data);
        chk("beat_done", LE_done, mon_e.done);
      end
    end
  end

  initial begin
    int n;
    int sx[6];
    int sy[6];
    sx = '{0, 0, 1, 1, 2, 2};
    sy = '{0, 1, 2, 3, 4, 5};
    rst = 1'b1;
    LE_color = 32'h0; LE_point = 10'h0;
    LE_color_valid = 1'b0; LE_x0_valid = 1'b0; LE_y0_valid = 1'b0;
    LE_x1_valid = 1'b0; LE_y1_valid = 1'b0;
    LE_mode = 1'b0; LE_trigger = 1'b0;
    LE_frame_base = 32'hF040_1234;
    bus.af_full = 1'b0;
    bus.wdf_full = 1'b0;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", LE_ready, 1'b1);
    chk("rst_af_wr", bus.af_wr_en, 1'b0);
    chk("rst_wdf_wr", bus.wdf_wr_en, 1'b0);
    chk("rst_done", LE_done, 1'b0);
    chk("rst_addr", bus.af_addr_din, 31'h0);
    chk("rst_mask", bus.wdf_mask_din, 16'h0);

    // Reset during SEND2 of the third burst of a 10-pixel line.
    load(10, 3, 19, 3, 32'h00AB_CDEF);
    for (int x = 10; x <= 19; x++) push_pix(x, 3, 32'h00AB_CDEF, x == 19);
    trigger(1'b0);
    n = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.wdf_wr_en && !bus.af_wr_en) n++;
      if (n == 3) break;
    end
    chk("rst_mid_send2_seen", n, 3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_mid_beats_written", exp_q.size(), 14);
    @(negedge clk);
    chk("rst_mid_af_wr", bus.af_wr_en, 1'b0);
    chk("rst_mid_wdf_wr", bus.wdf_wr_en, 1'b0);
    chk("rst_mid_ready", LE_ready, 1'b1);
    exp_q.delete();

    // Horizontal line (0,5)-(9,5) with first-write latency.
    load(0, 5, 9, 5, 32'h0011_2233);
    for (int x = 0; x < 9; x++) push_pix(x, 5, 32'h0011_2233, 1'b0);
    push_burst(31'h80A04, 16'hF0FF, 16'hFFFF, 32'h0011_2233, 1'b1);
    trigger(1'b0);
    @(negedge clk);
    chk("setup_no_af", bus.af_wr_en, 1'b0);
    @(negedge clk);
    chk("first_af_latency", bus.af_wr_en, 1'b1);
    finish_op("hline", 10);

    // Steep line, both endpoint orders.
    load(0, 0, 2, 5, 32'h0044_5566);
    for (int i = 0; i < 6; i++) push_pix(sx[i], sy[i], 32'h0044_5566, i == 5);
    trigger(1'b0);
    finish_op("steep", 6);
    load(2, 5, 0, 0, 32'h0077_8899);
    for (int i = 0; i < 6; i++) push_pix(sx[i], sy[i], 32'h0077_8899, i == 5);
    trigger(1'b0);
    finish_op("steep_swapped", 6);

    // Filled rectangle (2,0)-(13,1).
    load(2, 0, 13, 1, 32'h00FF_0000);
    push_burst(31'h80000, 16'hFF00, 16'h0000, 32'h00FF_0000, 1'b0);
    push_burst(31'h80004, 16'h0000, 16'h00FF, 32'h00FF_0000, 1'b0);
    push_burst(31'h80200, 16'hFF00, 16'h0000, 32'h00FF_0000, 1'b0);
    push_burst(31'h80204, 16'h0000, 16'h00FF, 32'h00FF_0000, 1'b1);
    trigger(1'b1);
    finish_op("rect", 4);

    // Backpressure: af_full blocks SEND1, wdf_full stalls SEND2 for 3 cycles.
    load(0, 5, 9, 5, 32'h0012_3456);
    for (int x = 0; x <= 9; x++) push_pix(x, 5, 32'h0012_3456, x == 9);
    bus.af_full = 1'b1;
    trigger(1'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("af_full_no_af", bus.af_wr_en, 1'b0);
      chk("af_full_no_wdf", bus.wdf_wr_en, 1'b0);
    end
    tick();
    bus.af_full = 1'b0;
    n = 0;
    while (bus.af_wr_en !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("bp_first_af", bus.af_wr_en, 1'b1);
    @(posedge clk);
    #1;
    bus.wdf_full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("wdf_stall_no_wdf", bus.wdf_wr_en, 1'b0);
      chk("wdf_stall_no_af", bus.af_wr_en, 1'b0);
      chk("wdf_stall_addr", bus.af_addr_din, 31'h80A00);
      chk("wdf_stall_mask", bus.wdf_mask_din, 16'hFFFF);
      chk("wdf_stall_data", bus.wdf_din, {4{32'h0012_3456}});
    end
    @(posedge clk);
    #1;
    bus.wdf_full = 1'b0;
    finish_op("backpressure", 10);

    // Degenerate line; trigger and load strobes while busy must not disturb it.
    load(4, 4, 4, 4, 32'h0000_00C3);
    push_burst(31'h80800, 16'hFFFF, 16'h0FFF, 32'h0000_00C3, 1'b1);
    trigger(1'b0);
    LE_mode = 1'b1; LE_trigger = 1'b1;
    LE_point = 10'd9; LE_x1_valid = 1'b1;
    tick();
    chk("busy_not_ready", LE_ready, 1'b0);
    tick();
    LE_trigger = 1'b0; LE_x1_valid = 1'b0;
    finish_op("degenerate", 1);
    af_cnt = 0;
    repeat (6) @(negedge clk);
    chk("busy_trigger_ignored", af_cnt, 0);
    chk("idle_after_ignored", LE_ready, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
